// File: rtl/decode_issue_queue_pkg.sv
// Shared widths, launch_flag bit indices and the queue entry layout for the decode issue queue.
package decode_issue_queue_pkg;

    localparam int unsigned PC_W        = 32;
    localparam int unsigned DECODEOUT_W = 32;
    localparam int unsigned IQ_ENTRY_W  = 2 * PC_W + DECODEOUT_W;

    // launch_flag bit positions: inst1/inst2 launched to exc1/exc2
    localparam int unsigned LF_I1_E1 = 3;
    localparam int unsigned LF_I1_E2 = 2;
    localparam int unsigned LF_I2_E1 = 1;
    localparam int unsigned LF_I2_E2 = 0;

    typedef struct packed {
        logic [PC_W-1:0]        pc;
        logic [PC_W-1:0]        npc;
        logic [DECODEOUT_W-1:0] decodeout;
    } iq_entry_t;

    function automatic iq_entry_t make_entry(
        input logic [PC_W-1:0]        pc,
        input logic [PC_W-1:0]        npc,
        input logic [DECODEOUT_W-1:0] decodeout
    );
        iq_entry_t e;
        e.pc        = pc;
        e.npc       = npc;
        e.decodeout = decodeout;
        return e;
    endfunction

endpackage

// File: rtl/decode_issue_queue_storage.sv
// Entry storage for the issue queue: DEPTH registers, two write ports, two async read ports.
module decode_issue_queue_storage
    import decode_issue_queue_pkg::*;
#(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned PW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  we0,
    input  logic [PW-1:0]         wa0,
    input  logic [IQ_ENTRY_W-1:0] wd0,
    input  logic                  we1,
    input  logic [PW-1:0]         wa1,
    input  logic [IQ_ENTRY_W-1:0] wd1,
    input  logic [PW-1:0]         ra0,
    input  logic [PW-1:0]         ra1,
    output logic [IQ_ENTRY_W-1:0] rd0,
    output logic [IQ_ENTRY_W-1:0] rd1
);

    logic [IQ_ENTRY_W-1:0] mem_q [DEPTH];
    logic [IQ_ENTRY_W-1:0] mem_d [DEPTH];

    // Contents are don't-care after reset, so the array carries no reset.
    always_comb begin
        mem_d = mem_q;
        if (we0) mem_d[wa0] = wd0;
        if (we1) mem_d[wa1] = wd1;
    end

    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end

    assign rd0 = mem_q[ra0];
    assign rd1 = mem_q[ra1];

endmodule

// File: rtl/decode_issue_queue.sv
// In-order 2-wide issue queue between decode and dual-issue launch select.
// Holds pointers, occupancy, push/pop arbitration, the sticky launch error and output masking.
module decode_issue_queue
    import decode_issue_queue_pkg::*;
#(
    parameter  int unsigned DEPTH = 8,
    localparam int unsigned PW    = $clog2(DEPTH)
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   flush,
    input  logic                   in_valid1,
    input  logic [PC_W-1:0]        in_pc1,
    input  logic [PC_W-1:0]        in_npc1,
    input  logic [DECODEOUT_W-1:0] in_decodeout1,
    input  logic                   in_valid2,
    input  logic [PC_W-1:0]        in_pc2,
    input  logic [PC_W-1:0]        in_npc2,
    input  logic [DECODEOUT_W-1:0] in_decodeout2,
    output logic                   in_ready,
    input  logic [3:0]             launch_flag,
    output logic [PC_W-1:0]        out1_pc,
    output logic [PC_W-1:0]        out1_npc,
    output logic [DECODEOUT_W-1:0] out1_decodeout,
    output logic                   receive_flag1,
    output logic [PC_W-1:0]        out2_pc,
    output logic [PC_W-1:0]        out2_npc,
    output logic [DECODEOUT_W-1:0] out2_decodeout,
    output logic                   receive_flag2,
    output logic [PW:0]            count,
    output logic                   err_launch
);

    logic [PW-1:0] head_q, head_d;
    logic [PW-1:0] tail_q, tail_d;
    logic [PW:0]   count_q, count_d;
    logic          err_q, err_d;

    logic          go1, go2, lf_illegal;
    logic [1:0]    req_pop, pop, push;
    logic          pop_err;
    logic          we0, we1;
    iq_entry_t     slot1, slot2, wd0, head_e, next_e;
    logic [IQ_ENTRY_W-1:0] rd0, rd1;

    assign in_ready = (count_q <= (PW+1)'(DEPTH - 2));

    // Launch feedback decode; an empty queue ignores launch_flag entirely.
    always_comb begin
        go1        = launch_flag[LF_I1_E1] | launch_flag[LF_I1_E2];
        go2        = launch_flag[LF_I2_E1] | launch_flag[LF_I2_E2];
        lf_illegal = (go2 & ~go1)
                   | (launch_flag[LF_I1_E1] & launch_flag[LF_I1_E2])
                   | (launch_flag[LF_I2_E1] & launch_flag[LF_I2_E2]);
        req_pop    = go1 ? (go2 ? 2'd2 : 2'd1) : 2'd0;
        pop        = 2'd0;
        pop_err    = 1'b0;
        if (count_q != '0) begin
            if (lf_illegal) begin
                pop_err = 1'b1;
            end else if ((PW+1)'(req_pop) > count_q) begin
                pop     = 2'(count_q);
                pop_err = 1'b1;
            end else begin
                pop = req_pop;
            end
        end
    end

    // Enqueue compaction: a lone valid slot always lands at tail.
    always_comb begin
        slot1 = make_entry(in_pc1, in_npc1, in_decodeout1);
        slot2 = make_entry(in_pc2, in_npc2, in_decodeout2);
        we0   = in_ready & (in_valid1 | in_valid2) & ~flush;
        we1   = in_ready & in_valid1 & in_valid2 & ~flush;
        wd0   = in_valid1 ? slot1 : slot2;
        push  = {1'b0, we0} + {1'b0, we1};
    end

    always_comb begin
        head_d  = head_q + PW'(pop);
        tail_d  = tail_q + PW'(push);
        count_d = count_q + (PW+1)'(push) - (PW+1)'(pop);
        err_d   = err_q | pop_err;
        if (flush) begin
            head_d  = '0;
            tail_d  = '0;
            count_d = '0;
            err_d   = err_q;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
            err_q   <= 1'b0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
            err_q   <= err_d;
        end
    end

    decode_issue_queue_storage #(
        .DEPTH (DEPTH),
        .PW    (PW)
    ) u_storage (
        .clk (clk),
        .we0 (we0),
        .wa0 (tail_q),
        .wd0 (wd0),
        .we1 (we1),
        .wa1 (tail_q + PW'(1)),
        .wd1 (slot2),
        .ra0 (head_q),
        .ra1 (head_q + PW'(1)),
        .rd0 (rd0),
        .rd1 (rd1)
    );

    // Data buses read zero whenever the matching entry is not valid.
    always_comb begin
        receive_flag1  = (count_q != '0);
        receive_flag2  = (count_q >= (PW+1)'(2));
        head_e         = rd0;
        next_e         = rd1;
        out1_pc        = receive_flag1 ? head_e.pc        : '0;
        out1_npc       = receive_flag1 ? head_e.npc       : '0;
        out1_decodeout = receive_flag1 ? head_e.decodeout : '0;
        out2_pc        = receive_flag2 ? next_e.pc        : '0;
        out2_npc       = receive_flag2 ? next_e.npc       : '0;
        out2_decodeout = receive_flag2 ? next_e.decodeout : '0;
        count          = count_q;
        err_launch     = err_q;
    end

endmodule
